// File: rtl/ripple_fx_seq.sv
// Three-ring ripple animation: frame-stepped ring sequencer with linear per-ring fade,
// plus a one-cycle pixel path that maps zone flags to a brightness level.
module ripple_fx_seq #(
  parameter int unsigned STEP_FRAMES = 4,
  parameter logic [7:0]  PEAK        = 8'd255,
  parameter logic [7:0]  DECAY_STEP  = 8'd32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic       judge1,
  input  logic       judge2,
  input  logic       judge3,
  output logic [7:0] bright,
  output logic       bright_valid,
  output logic       busy,
  output logic [1:0] ring_idx
);

  localparam int unsigned CntW = $clog2(STEP_FRAMES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_FRAMES - 1);

  typedef enum logic [2:0] {StIdle, StR1, StR2, StR3, StTail} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      lvl1_q, lvl1_d, lvl2_q, lvl2_d, lvl3_q, lvl3_d;
  logic [7:0]      dec1, dec2, dec3;
  logic [7:0]      bright_d;
  logic [1:0]      ring_idx_d;
  logic            counted;

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v > DECAY_STEP) ? v - DECAY_STEP : 8'd0;
  endfunction

  assign dec1    = sat_dec(lvl1_q);
  assign dec2    = sat_dec(lvl2_q);
  assign dec3    = sat_dec(lvl3_q);
  assign counted = frame_start && !trigger && (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl1_d  = lvl1_q;
    lvl2_d  = lvl2_q;
    lvl3_d  = lvl3_q;
    if (trigger) begin
      // Restart wins over any same-cycle frame pulse; other rings keep fading later.
      state_d = StR1;
      cnt_d   = '0;
      lvl1_d  = PEAK;
    end else if (counted) begin
      unique case (state_q)
        StR1: begin
          if (cnt_q == CntLast) begin
            state_d = StR2;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StR2: begin
          if (cnt_q == CntLast) begin
            state_d = StR3;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StR3: begin
          if (cnt_q == CntLast) begin
            state_d = StTail;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StTail: begin
          if (dec1 == 8'd0 && dec2 == 8'd0 && dec3 == 8'd0) state_d = StIdle;
        end
        default: ;
      endcase
      lvl1_d = (state_d == StR1) ? PEAK : dec1;
      lvl2_d = (state_d == StR2) ? PEAK : dec2;
      lvl3_d = (state_d == StR3) ? PEAK : dec3;
    end
  end

  always_comb begin
    unique case (state_d)
      StR1:    ring_idx_d = 2'd1;
      StR2:    ring_idx_d = 2'd2;
      StR3:    ring_idx_d = 2'd3;
      default: ring_idx_d = 2'd0;
    endcase
  end

  always_comb begin
    bright_d = 8'd0;
    if (pix_valid) begin
      if (judge1)      bright_d = lvl1_q;
      else if (judge2) bright_d = lvl2_q;
      else if (judge3) bright_d = lvl3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      lvl1_q       <= 8'd0;
      lvl2_q       <= 8'd0;
      lvl3_q       <= 8'd0;
      bright       <= 8'd0;
      bright_valid <= 1'b0;
      busy         <= 1'b0;
      ring_idx     <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lvl1_q       <= lvl1_d;
      lvl2_q       <= lvl2_d;
      lvl3_q       <= lvl3_d;
      bright       <= bright_d;
      bright_valid <= pix_valid;
      busy         <= (state_d != StIdle);
      ring_idx     <= ring_idx_d;
    end
  end

endmodule

// File: tb/tb_ripple_fx_seq.sv
// Directed bench for ripple_fx_seq: default-parameter instance plus a saturating-decay instance
// sharing the same stimulus.
module tb_ripple_fx_seq;

  logic       clk, rst_n, trigger, frame_start, pix_valid, judge1, judge2, judge3;
  logic [7:0] bright, bright_s;
  logic       bright_valid, bright_valid_s, busy, busy_s;
  logic [1:0] ring_idx, ring_idx_s;

  int n_total = 0;
  int n_pass  = 0;

  ripple_fx_seq dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .frame_start(frame_start),
    .pix_valid(pix_valid), .judge1(judge1), .judge2(judge2), .judge3(judge3),
    .bright(bright), .bright_valid(bright_valid), .busy(busy), .ring_idx(ring_idx)
  );

  ripple_fx_seq #(.STEP_FRAMES(4), .PEAK(8'd150), .DECAY_STEP(8'd100)) dut_sat (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .frame_start(frame_start),
    .pix_valid(pix_valid), .judge1(judge1), .judge2(judge2), .judge3(judge3),
    .bright(bright_s), .bright_valid(bright_valid_s), .busy(busy_s), .ring_idx(ring_idx_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pv, j1, j2, j3;
    logic [7:0] exp_b;
    logic       exp_v;
  } vec_t;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic probe(input logic a, input logic b, input logic c, input string nm,
                       input logic [7:0] exp);
    pix_valid = 1'b1; judge1 = a; judge2 = b; judge3 = c;
    tick();
    check(nm, bright, exp);
    pix_valid = 1'b0; judge1 = 1'b0; judge2 = 1'b0; judge3 = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd95,  1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd223, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd95,  1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd223, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0};

    rst_n = 1'b0; trigger = 1'b0; frame_start = 1'b0;
    pix_valid = 1'b0; judge1 = 1'b0; judge2 = 1'b0; judge3 = 1'b0;
    #12;
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_ring", {6'd0, ring_idx}, 8'd0);
    check("reset_bright", bright, 8'd0);
    rst_n = 1'b1;
    tick();

    probe(1'b0, 1'b1, 1'b0, "idle_lvl2", 8'd0);
    check("idle_valid", {7'd0, bright_valid}, 8'd1);

    // Trigger from idle
    pulse_trigger();
    check("trig_busy", {7'd0, busy}, 8'd1);
    check("trig_ring", {6'd0, ring_idx}, 8'd1);
    probe(1'b1, 1'b0, 1'b0, "trig_lvl1", 8'd255);
    check("trig_valid", {7'd0, bright_valid}, 8'd1);

    frames(3);
    check("r1_hold_ring", {6'd0, ring_idx}, 8'd1);
    frames(1);
    check("r2_ring", {6'd0, ring_idx}, 8'd2);
    probe(1'b1, 1'b0, 1'b0, "r2_lvl1", 8'd223);
    probe(1'b0, 1'b1, 1'b0, "r2_lvl2", 8'd255);
    probe(1'b1, 1'b1, 1'b1, "r2_prio", 8'd223);
    probe(1'b1, 1'b0, 1'b0, "sat_r2_lvl1", 8'd223);
    check("sat_after_step", bright_s, 8'd50);

    // Pixel sampled alongside a level update sees pre-update levels
    frame_start = 1'b1; pix_valid = 1'b1; judge1 = 1'b1;
    tick();
    check("pre_update_lvl1", bright, 8'd223);
    check("sat_pre_update", bright_s, 8'd50);
    frame_start = 1'b0; pix_valid = 1'b0; judge1 = 1'b0;
    tick();
    probe(1'b1, 1'b0, 1'b0, "post_update_lvl1", 8'd191);
    check("sat_saturated", bright_s, 8'd0);

    frames(3);
    check("r3_ring", {6'd0, ring_idx}, 8'd3);
    for (int i = 0; i < 8; i++) begin
      pix_valid = tbl[i].pv; judge1 = tbl[i].j1; judge2 = tbl[i].j2; judge3 = tbl[i].j3;
      tick();
      check($sformatf("tbl%0d_bright", i), bright, tbl[i].exp_b);
      check($sformatf("tbl%0d_valid", i), {7'd0, bright_valid}, {7'd0, tbl[i].exp_v});
    end
    pix_valid = 1'b0; judge1 = 1'b0; judge2 = 1'b0; judge3 = 1'b0;

    frames(4);
    check("tail_ring", {6'd0, ring_idx}, 8'd0);
    check("tail_busy", {7'd0, busy}, 8'd1);
    probe(1'b1, 1'b0, 1'b0, "tail_lvl1", 8'd0);
    probe(1'b0, 1'b1, 1'b0, "tail_lvl2", 8'd95);
    probe(1'b0, 1'b0, 1'b1, "tail_lvl3", 8'd223);

    frames(6);
    check("frame18_busy", {7'd0, busy}, 8'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("frame19_idle", {7'd0, busy}, 8'd0);
    tick();
    frames(2);
    check("idle_ignores_frames", {7'd0, busy}, 8'd0);
    probe(1'b0, 1'b0, 1'b1, "idle_lvl3", 8'd0);

    // Retrigger during R3 with a coincident frame pulse
    pulse_trigger();
    frames(9);
    check("rt_pre_ring", {6'd0, ring_idx}, 8'd3);
    trigger = 1'b1; frame_start = 1'b1;
    tick();
    trigger = 1'b0; frame_start = 1'b0;
    check("rt_ring", {6'd0, ring_idx}, 8'd1);
    probe(1'b1, 1'b0, 1'b0, "rt_lvl1", 8'd255);
    probe(1'b0, 1'b1, 1'b0, "rt_lvl2", 8'd191);
    probe(1'b0, 1'b0, 1'b1, "rt_lvl3", 8'd255);
    frames(3);
    check("rt_cnt_reset", {6'd0, ring_idx}, 8'd1);
    probe(1'b0, 1'b1, 1'b0, "rt_lvl2_decay", 8'd95);
    probe(1'b0, 1'b0, 1'b1, "rt_lvl3_decay", 8'd159);
    frames(1);
    check("rt_r2_ring", {6'd0, ring_idx}, 8'd2);

    // Asynchronous reset mid-R2
    pix_valid = 1'b1; judge2 = 1'b1;
    tick();
    check("pre_rst_bright", bright, 8'd255);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bright", bright, 8'd0);
    check("arst_valid", {7'd0, bright_valid}, 8'd0);
    check("arst_busy", {7'd0, busy}, 8'd0);
    check("arst_ring", {6'd0, ring_idx}, 8'd0);
    #1;
    rst_n = 1'b1;
    pix_valid = 1'b0; judge2 = 1'b0;
    tick();
    probe(1'b0, 1'b1, 1'b0, "post_rst_lvl2", 8'd0);
    check("post_rst_busy", {7'd0, busy}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
